// File: rtl/periph_lsu.sv
// periph_lsu: core load/store to word-addressed peripheral bus adapter.
// Accepts one request at a time (req_ready only in IDLE), drives byte enables
// and lane-replicated store data, and returns sign/zero-extended load data.
// Misaligned or illegal requests are answered with rsp_err and no bus activity.
// Optional build macro PERIPH_LSU_RANGE_CHECK_EN: rejects addresses whose
// upper bits [31:ADDR_W+2] differ from BASE_ADDR.
module periph_lsu #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] p_addr,
  output logic [3:0]        p_be,
  output logic [31:0]       p_wdata,
  output logic              p_we,
  input  logic [31:0]       p_q
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d;
  logic [3:0]        p_be_q, p_be_d;
  logic [31:0]       p_wdata_q, p_wdata_d;
  logic              p_we_q, p_we_d;

  logic [3:0]        size_be;
  logic [31:0]       size_wdata;
  logic              f3_legal;
  logic              misaligned;
  logic              range_ok;
  logic              req_ok;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       rdata_c;

`ifdef PERIPH_LSU_RANGE_CHECK_EN
  assign range_ok = (req_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
`else
  logic unused_upper;
  assign range_ok     = 1'b1;
  assign unused_upper = ^{req_addr[31:ADDR_W+2], BASE_ADDR};
`endif

  // Decode the incoming request: byte enables, replicated data, legality.
  always_comb begin
    size_be    = '0;
    size_wdata = '0;
    unique case (req_funct3[1:0])
      2'b00: begin
        size_be    = 4'b0001 << req_addr[1:0];
        size_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        size_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        size_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        size_be    = 4'b1111;
        size_wdata = req_wdata;
      end
      default: begin
        size_be    = '0;
        size_wdata = '0;
      end
    endcase

    if (req_we) begin
      f3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      f3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    req_ok = f3_legal && !misaligned && range_ok;
  end

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    p_addr_d    = '0;
    p_be_d      = '0;
    p_wdata_d   = '0;
    p_we_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          f3_d        = req_funct3;
          lane_d      = req_addr[1:0];
          if (!req_ok) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d     = WRITE;
            rsp_valid_d = 1'b1;
            p_we_d      = 1'b1;
            p_addr_d    = req_addr[ADDR_W+1:2];
            p_be_d      = size_be;
            p_wdata_d   = size_wdata;
          end else begin
            state_d  = READ;
            cnt_d    = LAT_M1;
            p_addr_d = req_addr[ADDR_W+1:2];
            p_be_d   = size_be;
          end
        end
      end
      WRITE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      READ: begin
        p_addr_d = p_addr_q;
        p_be_d   = p_be_q;
        if (cnt_q == 3'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register FSM state and all bus/response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      p_addr_q    <= '0;
      p_be_q      <= '0;
      p_wdata_q   <= '0;
      p_we_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      p_addr_q    <= p_addr_d;
      p_be_q      <= p_be_d;
      p_wdata_q   <= p_wdata_d;
      p_we_q      <= p_we_d;
    end
  end

  // Extract and extend load data from p_q while a good load response is shown.
  always_comb begin
    unique case (lane_q)
      2'd0:    byte_sel = p_q[7:0];
      2'd1:    byte_sel = p_q[15:8];
      2'd2:    byte_sel = p_q[23:16];
      default: byte_sel = p_q[31:24];
    endcase
    half_sel = lane_q[1] ? p_q[31:16] : p_q[15:0];

    rdata_c = '0;
    if ((state_q == RESP) && !rsp_err_q) begin
      unique case (f3_q)
        3'b000:  rdata_c = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  rdata_c = {24'd0, byte_sel};
        3'b001:  rdata_c = {{16{half_sel[15]}}, half_sel};
        3'b101:  rdata_c = {16'd0, half_sel};
        3'b010:  rdata_c = p_q;
        default: rdata_c = '0;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_c;
  assign p_addr    = p_addr_q;
  assign p_be      = p_be_q;
  assign p_wdata   = p_wdata_q;
  assign p_we      = p_we_q;

endmodule

// File: tb/tb_periph_lsu.sv
// Testbench for periph_lsu: directed and random load/store traffic against a
// byte-level reference model; a latency-accurate peripheral model supplies p_q.
module tb_periph_lsu;

  localparam int unsigned TB_LAT  = 2;
  localparam logic [31:0] TB_BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  p_addr;
  logic [3:0]  p_be;
  logic [31:0] p_wdata;
  logic        p_we;
  logic [31:0] p_q;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pmem    [256];
  logic [31:0] ref_mem [256];
  logic [31:0] q_pipe  [TB_LAT];

  periph_lsu #(
    .ADDR_W   (8),
    .READ_LAT (TB_LAT),
    .BASE_ADDR(TB_BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .p_addr    (p_addr),
    .p_be      (p_be),
    .p_wdata   (p_wdata),
    .p_we      (p_we),
    .p_q       (p_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Peripheral: byte-enabled writes, reads returned TB_LAT cycles after p_addr.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) pmem[i] <= init_val(i);
    end else begin
      if (p_we) begin
        for (int k = 0; k < 4; k++)
          if (p_be[k]) pmem[p_addr][8*k +: 8] <= p_wdata[8*k +: 8];
      end
    end
    q_pipe[0] <= pmem[p_addr];
    for (int i = 1; i < TB_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign p_q = q_pipe[TB_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic init_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rvalid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rerr"}, 32'(rsp_err), 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_paddr"}, 32'(p_addr), 32'd0);
    check({tag, "_pbe"}, 32'(p_be), 32'd0);
    check({tag, "_pwdata"}, p_wdata, 32'd0);
    check({tag, "_pwe"}, 32'(p_we), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  // One request: model predicts error/bus/response, checked every cycle.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd);
    int unsigned nb, lane, idx, lat;
    logic        legal, aligned, in_range, err, sgn;
    logic [3:0]  be;
    logic [31:0] pw, exp_rd, mask, v;
    nb   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    lane = addr % 4;
    idx  = (addr / 4) % 256;
    legal   = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    aligned = (nb != 0) && ((addr % nb) == 0);
`ifdef PERIPH_LSU_RANGE_CHECK_EN
    in_range = (addr[31:10] == TB_BASE[31:10]);
`else
    in_range = 1'b1;
`endif
    err = !(legal && aligned && in_range);
    be = '0;
    pw = '0;
    for (int k = 0; k < 4; k++) begin
      if (k >= lane && k < lane + nb) be[k] = 1'b1;
      if (nb != 0) pw[8*k +: 8] = wdata[8*(k % nb) +: 8];
    end
    exp_rd = '0;
    if (!err && !we) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      v    = (ref_mem[idx] >> (8*lane)) & mask;
      sgn  = !f3[2];
      if (sgn && v[8*nb-1]) v = v | ~mask;
      exp_rd = v;
    end
    lat = err ? 1 : (we ? 1 : 1 + TB_LAT);

    wait_ready(tag);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    rd = '0;
    for (int unsigned c = 1; c <= lat; c++) begin
      @(negedge clk);
      check({tag, "_rvalid"}, 32'(rsp_valid), 32'(c == lat));
      check({tag, "_pwe"}, 32'(p_we), 32'(!err && we && c == 1));
      if (err) begin
        check({tag, "_pbe"}, 32'(p_be), 32'd0);
      end else begin
        check({tag, "_paddr"}, 32'(p_addr), 32'(idx));
        check({tag, "_pbe"}, 32'(p_be), 32'(be));
        if (we) check({tag, "_pwdata"}, p_wdata, pw);
      end
      if (c == lat) begin
        check({tag, "_rerr"}, 32'(rsp_err), 32'(err));
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        rd = rsp_rdata;
      end
    end
    if (!err && we) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) ref_mem[idx][8*k +: 8] = pw[8*k +: 8];
    end
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_idle_rvalid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle_pwe"}, 32'(p_we), 32'd0);
    check({tag, "_idle_pbe"}, 32'(p_be), 32'd0);
    check({tag, "_idle_paddr"}, 32'(p_addr), 32'd0);
    check({tag, "_idle_pwdata"}, p_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] up;
    int n;

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    init_ref();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    do_req("sw_254", 1'b1, 3'b010, TB_BASE | 32'h254, 32'h0005_00A3, rd);
    do_req("sb_3fe", 1'b1, 3'b000, TB_BASE | 32'h3FE, 32'h1234_56AB, rd);
    do_req("sw_000", 1'b1, 3'b010, TB_BASE | 32'h000, 32'h80FF_0000, rd);
    do_req("lb_003", 1'b0, 3'b000, TB_BASE | 32'h003, 32'h0, rd);
    check("lb_const", rd, 32'hFFFF_FF80);
    do_req("lbu_003", 1'b0, 3'b100, TB_BASE | 32'h003, 32'h0, rd);
    check("lbu_const", rd, 32'h0000_0080);
    do_req("lh_mis", 1'b0, 3'b001, TB_BASE | 32'h001, 32'h0, rd);
    do_req("ld_f3_011", 1'b0, 3'b011, TB_BASE | 32'h000, 32'h0, rd);
    do_req("sw_mis", 1'b1, 3'b010, TB_BASE | 32'h102, 32'hDEAD_BEEF, rd);
    do_req("st_f3_100", 1'b1, 3'b100, TB_BASE | 32'h100, 32'hDEAD_BEEF, rd);
    do_req("sh_hi", 1'b1, 3'b001, TB_BASE | 32'h0A2, 32'hCAFE_8765, rd);
    do_req("lh_hi", 1'b0, 3'b001, TB_BASE | 32'h0A2, 32'h0, rd);
    do_req("lhu_hi", 1'b0, 3'b101, TB_BASE | 32'h0A2, 32'h0, rd);
    do_req("lw_254", 1'b0, 3'b010, TB_BASE | 32'h254, 32'h0, rd);
    do_req("sw_rng_out", 1'b1, 3'b010, 32'h0000_0010, 32'h1111_2222, rd);
    do_req("sw_rng_in", 1'b1, 3'b010, 32'h4000_0010, 32'h3333_4444, rd);
    do_req("lw_rng_in", 1'b0, 3'b010, 32'h4000_0010, 32'h0, rd);

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      up = ($urandom_range(0, 7) == 0) ? $urandom : TB_BASE;
      a  = {up[31:10], 10'($urandom)};
      do_req("rand", 1'($urandom), 3'($urandom), a, $urandom, rd);
    end

    // Reset in the middle of a load: everything drops to 0, no response later
    wait_ready("mid");
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = TB_BASE | 32'h040;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_read_pbe", 32'(p_be), 32'hF);
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || p_we !== 1'b0) n++;
    end
    check("mid_no_rsp_or_write", 32'(n), 32'd0);
    check("mid_ready_after", 32'(req_ready), 32'd1);
    init_ref();
    do_req("post_lw", 1'b0, 3'b010, TB_BASE | 32'h040, 32'h0, rd);
    do_req("post_sb", 1'b1, 3'b000, TB_BASE | 32'h041, 32'h0000_005C, rd);
    do_req("post_lbu", 1'b0, 3'b100, TB_BASE | 32'h041, 32'h0, rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/periph_lsu.md
Name: periph_lsu

Overview:
Load/store adapter upstream of the memory-mapped peripherals (GPIO and siblings). It turns core load/store requests (byte address, RV32 funct3 size) into the word-addressed peripheral bus: addr, be, wdata, we in, q out. It returns sign/zero-extended load data to the core through a valid/ready handshake, and flags misaligned or illegal accesses without touching the bus.

Parameters:
ADDR_W, 8, peripheral word-address width; p_addr = req_addr[ADDR_W+1:2]
READ_LAT, 1, cycles from p_addr presented to p_q valid (legal range 1..7)
BASE_ADDR, 32'h0000_0000, peripheral window base (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  adapter can accept (state IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response strobe
rsp_err  out  1  access rejected; qualified by rsp_valid
rsp_rdata  out  32  extended load data; 0 for stores and errors
p_addr  out  ADDR_W  peripheral word address
p_be  out  4  peripheral byte enables
p_wdata  out  32  lane-replicated store data
p_we  out  1  peripheral write strobe
p_q  in  32  peripheral read data

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including req_ready.
- FSM states: IDLE, WRITE, READ, RESP.
- Handshake: a request is accepted when req_valid & req_ready at a rising edge. Inputs are registered at acceptance. req_ready=1 only in IDLE, so there is exactly one outstanding request.
- Legality check at acceptance:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - Store funct3 not in {000,001,010} is illegal.
  - Load funct3 not in {000,001,010,100,101} is illegal.
  - Misaligned/illegal -> RESP with error: rsp_valid=1, rsp_err=1, rsp_rdata=0. p_we stays 0 and p_be stays 0 throughout.
- Store path, IDLE -> WRITE (1 cycle) -> IDLE:
  - In WRITE: p_we=1, and rsp_valid=1, rsp_err=0.
  - SB: p_be = 4'b0001 << addr[1:0]; p_wdata = {4{wdata[7:0]}}.
  - SH: p_be = addr[1] ? 4'b1100 : 4'b0011; p_wdata = {2{wdata[15:0]}}.
  - SW: p_be = 4'b1111; p_wdata = wdata.
  - Store response arrives 1 cycle after acceptance.
- Load path, IDLE -> READ (READ_LAT cycles, counter) -> RESP (1 cycle) -> IDLE:
  - p_addr and p_be are driven from the first READ cycle through RESP; p_we=0.
  - In RESP, rsp_rdata is extracted combinationally from p_q:
    - LB/LBU: byte at lane addr[1:0], sign/zero-extended.
    - LH/LHU: half at addr[1], sign/zero-extended.
    - LW: p_q unchanged.
  - Load response arrives 1+READ_LAT cycles after acceptance.
- Outside WRITE, p_we=0. In IDLE, p_addr, p_be and p_wdata hold 0.
- Back-to-back: a new request can be accepted in the IDLE cycle directly following WRITE or RESP. There is no combinational path from req_valid to req_ready.
- Reset mid-operation: immediate return to IDLE and all outputs 0. The in-flight request is dropped with no response, and no partial write is issued after reset release.

Optional Feature:
Macro PERIPH_LSU_RANGE_CHECK_EN.
- Defined: at acceptance, req_addr[31:ADDR_W+2] must equal BASE_ADDR[31:ADDR_W+2]. Otherwise the request takes the error path (rsp_err=1, no bus activity); misalignment/illegal checks still apply.
- Undefined: the upper address bits are ignored and BASE_ADDR is unused.

Test Plan:
- Reset: assert rst=0 mid-load (READ state) -> all outputs 0 at once; after release, req_ready=1 and no rsp_valid for the dropped load.
- SW: addr=0x254, wdata=0x000500A3 -> one cycle later p_we=1, p_addr=8'h95, p_be=1111, p_wdata=0x000500A3, rsp_valid=1, rsp_err=0.
- SB: addr=0x3FE, wdata=0x1234_56AB -> p_addr=8'hFF, p_be=0100, p_wdata=0xABABABAB.
- LB then LBU: addr=0x003, p_q=0x80FF_0000, READ_LAT=1 -> rsp_valid 2 cycles after accept; LB gives rsp_rdata=0xFFFFFF80, LBU gives 0x00000080.
- Misaligned LH at addr=0x001 and illegal funct3=011 -> rsp_valid=1, rsp_err=1, rsp_rdata=0, p_we=0 and p_be=0 throughout.
- Range check (macro defined, BASE_ADDR=0x4000_0000): SW to 0x0000_0010 -> rsp_err=1, no p_we; SW to 0x4000_0010 -> normal write, p_addr=8'h04.
